// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer RAM arbiter between VGA display reads and draw-engine writes
// Display wins during active video, draw wins during blanking, and a stalled draw is force-granted after MAX_WAIT cycles.
module vga_fb_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 12,
  parameter int MAX_WAIT = 8
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iBLANK,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              draw_valid,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_data,
  output logic              draw_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic [7:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_rd_v1;
  logic              r_rd_v2;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic w_force;
  logic w_gnt;
  logic w_ready;
  logic w_draw_xfer;

  always_comb begin
    w_force = !iBLANK && (r_wait_cnt == MAX_W) && draw_valid;
    w_gnt   = 1'b0;
    w_ready = 1'b0;
    if (!iRST_n) begin
      w_gnt   = 1'b0;
      w_ready = 1'b0;
    end else if (iBLANK) begin
      w_ready = 1'b1;
      w_gnt   = disp_req && !draw_valid;
    end else if (w_force) begin
      // One display pixel is sacrificed so the draw engine cannot starve.
      w_ready = 1'b1;
      w_gnt   = 1'b0;
    end else begin
      w_gnt   = disp_req;
      w_ready = !disp_req;
    end
    w_draw_xfer = draw_valid && w_ready;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_wait_cnt <= 8'd0;
    end else if (iBLANK || !draw_valid || w_draw_xfer) begin
      r_wait_cnt <= 8'd0;
    end else if (r_wait_cnt < MAX_W) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
    end else if (w_draw_xfer) begin
      r_ram_addr  <= draw_addr;
      r_ram_wdata <= draw_data;
      r_ram_we    <= 1'b1;
    end else if (w_gnt) begin
      r_ram_addr  <= disp_addr;
      r_ram_we    <= 1'b0;
    end else begin
      r_ram_we    <= 1'b0;
    end
  end

  // Read valid travels with the access: issue, RAM output, then registered data.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_rd_v1  <= 1'b0;
      r_rd_v2  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rd_v1  <= w_gnt;
      r_rd_v2  <= r_rd_v1;
      r_rvalid <= r_rd_v2;
      if (r_rd_v2) begin
        r_rdata <= ram_rdata;
      end
    end
  end

  assign disp_gnt    = w_gnt;
  assign draw_ready  = w_ready;
  assign ram_addr    = r_ram_addr;
  assign ram_we      = r_ram_we;
  assign ram_wdata   = r_ram_wdata;
  assign disp_rvalid = r_rvalid;
  assign disp_rdata  = r_rdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter with RAM model and read scoreboard
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        iRST_n;
  logic        iBLANK;
  logic        disp_req;
  logic [16:0] disp_addr;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [11:0] disp_rdata;
  logic        draw_valid;
  logic [16:0] draw_addr;
  logic [11:0] draw_data;
  logic        draw_ready;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rv_count = 0;
  logic use_fn = 1'b1;

  logic [11:0] mem [256];
  logic [11:0] shadow [256];

  typedef struct {
    logic [11:0] data;
    int          cyc;
  } sb_t;
  sb_t q[$];

  typedef struct {
    logic        blank;
    logic        req;
    logic        dv;
    logic [16:0] waddr;
    logic [11:0] wdata;
    logic        exp_gnt;
    logic        exp_rdy;
  } vec_t;
  vec_t vecs[10];

  vga_fb_arbiter #(.ADDR_W(17), .DATA_W(12), .MAX_WAIT(8)) dut (
    .iCLK(clk), .iRST_n(iRST_n), .iBLANK(iBLANK),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .draw_valid(draw_valid), .draw_addr(draw_addr), .draw_data(draw_data),
    .draw_ready(draw_ready), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= use_fn ? 12'(ram_addr + 17'h100) : mem[ram_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected read data is queued at grant and retired at rvalid.
  always @(negedge clk) begin
    if (!iRST_n) begin
      q.delete();
    end else begin
      if (disp_rvalid) begin
        sb_t e;
        rv_count++;
        if (q.size() == 0) begin
          chk("sb_spurious_rvalid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_rdata", 32'(disp_rdata), 32'(e.data));
          chk("sb_latency", 32'(cyc - e.cyc), 3);
        end
      end
      if (disp_gnt)
        q.push_back('{data: (use_fn ? 12'(disp_addr + 17'h100) : shadow[disp_addr[7:0]]), cyc: cyc});
      if (draw_valid && draw_ready) shadow[draw_addr[7:0]] = draw_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("sb_drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    int rv0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 12'h0;
      shadow[i] = 12'h0;
    end
    vecs[0] = '{1'b1, 1'b0, 1'b0, 17'h50, 12'h000, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 17'h51, 12'h000, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 17'h52, 12'h111, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 17'h53, 12'h222, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 17'h54, 12'h000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 17'h55, 12'h000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 17'h56, 12'h333, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 17'h57, 12'h444, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 17'h57, 12'h444, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 17'h57, 12'h444, 1'b0, 1'b1};

    // Reset hold with both requesters active
    iRST_n = 1'b0; iBLANK = 1'b0; disp_req = 1'b1; disp_addr = 17'h3;
    draw_valid = 1'b1; draw_addr = 17'h9; draw_data = 12'hFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_gnt", 32'(disp_gnt), 0);
      chk("rst_ready", 32'(draw_ready), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_wdata", 32'(ram_wdata), 0);
      chk("rst_rvalid", 32'(disp_rvalid), 0);
      chk("rst_rdata", 32'(disp_rdata), 0);
      chk("rst_wait_cnt", 32'(dut.r_wait_cnt), 0);
    end
    step();
    iRST_n = 1'b1; draw_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", 32'(disp_gnt), 1);
    step();
    disp_req = 1'b0;
    drain();

    // Active-video read stream
    rv0 = rv_count;
    iBLANK = 1'b0;
    for (int i = 0; i < 16; i++) begin
      disp_req = 1'b1; disp_addr = 17'(i);
      @(negedge clk);
      chk("stream_gnt", 32'(disp_gnt), 1);
      chk("stream_no_we", 32'(ram_we), 0);
      step();
    end
    disp_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stream_no_we", 32'(ram_we), 0);
      step();
    end
    drain();
    chk("stream_rv_count", 32'(rv_count - rv0), 16);

    // Mode table, backed by the RAM model
    use_fn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iBLANK = vecs[i].blank; disp_req = vecs[i].req; draw_valid = vecs[i].dv;
      disp_addr = 17'h50 + 17'(i); draw_addr = vecs[i].waddr; draw_data = vecs[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'(disp_gnt), 32'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d_ready", i), 32'(draw_ready), 32'(vecs[i].exp_rdy));
      step();
    end
    disp_req = 1'b0; draw_valid = 1'b0;
    drain();

    // Read back the table's writes
    iBLANK = 1'b0;
    for (int i = 2; i < 4; i++) begin
      disp_req = 1'b1; disp_addr = 17'h50 + 17'(i);
      step();
    end
    disp_req = 1'b0;
    drain();

    // Starvation and forced draw slot
    use_fn = 1'b1;
    iBLANK = 1'b0; disp_req = 1'b1; disp_addr = 17'h80;
    draw_valid = 1'b1; draw_addr = 17'h1234; draw_data = 12'hABC;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_ready", k), 32'(draw_ready), (k == 8) ? 1 : 0);
      chk($sformatf("starve%0d_gnt", k), 32'(disp_gnt), (k == 8) ? 0 : 1);
      step();
      disp_addr = disp_addr + 17'd1;
    end
    draw_valid = 1'b0;
    @(negedge clk);
    chk("force_ram_we", 32'(ram_we), 1);
    chk("force_ram_addr", 32'(ram_addr), 32'h1234);
    chk("force_ram_wdata", 32'(ram_wdata), 32'hABC);
    chk("force_gnt_back", 32'(disp_gnt), 1);
    chk("force_wait_clr", 32'(dut.r_wait_cnt), 0);
    step();
    disp_req = 1'b0;
    drain();

    // Blanking priority: five writes then display regains the slot
    use_fn = 1'b0;
    iBLANK = 1'b1; disp_req = 1'b1; disp_addr = 17'h20;
    for (int i = 0; i < 5; i++) begin
      draw_valid = 1'b1; draw_addr = 17'h20 + 17'(i); draw_data = 12'h300 + 12'(i);
      @(negedge clk);
      chk("blank_gnt", 32'(disp_gnt), 0);
      chk("blank_ready", 32'(draw_ready), 1);
      if (i > 0) chk("blank_we", 32'(ram_we), 1);
      step();
    end
    draw_valid = 1'b0; disp_addr = 17'h22;
    @(negedge clk);
    chk("blank_last_we", 32'(ram_we), 1);
    chk("blank_gnt_after", 32'(disp_gnt), 1);
    step();
    disp_req = 1'b0;
    drain();

    // Read-after-write to the same address
    iBLANK = 1'b1; draw_valid = 1'b1; draw_addr = 17'd7; draw_data = 12'h5A5; disp_req = 1'b0;
    step();
    draw_valid = 1'b0; disp_req = 1'b1; disp_addr = 17'd7;
    step();
    disp_req = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("raw_rvalid", 32'(disp_rvalid), 1);
    chk("raw_rdata", 32'(disp_rdata), 32'h5A5);
    step();
    drain();

    // Reset while two reads are in flight
    use_fn = 1'b1;
    rv0 = rv_count;
    iBLANK = 1'b0; disp_req = 1'b1; disp_addr = 17'h60;
    step();
    disp_addr = 17'h61;
    step();
    disp_req = 1'b0; iRST_n = 1'b0;
    step();
    step();
    iRST_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("midrst_no_rvalid", 32'(rv_count - rv0), 0);
    chk("midrst_q_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
